// File: rtl/b06_pkg.sv
// ---------------------------------------------------------------------------
// b06_pkg : state and output-code encodings for the b06 interrupt handler FSM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package b06_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_WAIT   = 3'd1,
    S_INTR_1 = 3'd2,
    S_INTR   = 3'd3,
    S_INTR_W = 3'd4,
    S_ENIN   = 3'd5,
    S_ENIN_W = 3'd6
  } state_t;

  localparam logic [1:0] CC_ENIN  = 2'b01;
  localparam logic [1:0] CC_INTR  = 2'b10;
  localparam logic [1:0] CC_ACKIN = 2'b11;

  localparam logic [1:0] OUT_NORM = 2'b01;
  localparam logic [1:0] OUT_IDLE = 2'b00;
  localparam logic [1:0] OUT_INTR = 2'b11;

endpackage : b06_pkg

`default_nettype wire

// File: rtl/b06_fsm.sv
// ---------------------------------------------------------------------------
// b06_fsm : enable/interrupt/ack handshake controller driven by eql/cont_eql
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module b06_fsm
  import b06_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_eql,
  input  logic       i_cont_eql,
  input  logic       i_obs,
  output logic [1:0] o_cc_mux,
  output logic [1:0] o_uscite,
  output logic       o_enable_count,
  output logic       o_ackout
);

  state_t     r_state;
  logic [1:0] r_cc_mux;
  logic [1:0] r_uscite;
  logic       r_enable_count;
  logic       r_ackout;

  state_t     w_state_nxt;
  logic [1:0] w_cc_mux_nxt;
  logic [1:0] w_uscite_nxt;
  logic       w_enable_count_nxt;
  logic       w_ackout_nxt;

  // Observation strobe is a pure sink.
  logic w_obs_unused;
  assign w_obs_unused = i_obs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_INIT;
      r_cc_mux       <= 2'b00;
      r_uscite       <= 2'b00;
      r_enable_count <= 1'b0;
      r_ackout       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cc_mux       <= w_cc_mux_nxt;
      r_uscite       <= w_uscite_nxt;
      r_enable_count <= w_enable_count_nxt;
      r_ackout       <= w_ackout_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = S_INIT;
    w_cc_mux_nxt       = r_cc_mux;
    w_uscite_nxt       = r_uscite;
    // cont_eql clears ack/enable unless a row below sets them explicitly.
    w_enable_count_nxt = i_cont_eql ? 1'b0 : r_enable_count;
    w_ackout_nxt       = i_cont_eql ? 1'b0 : r_ackout;

    case (r_state)
      S_WAIT: begin
        if (i_eql) begin
          w_uscite_nxt = OUT_IDLE;
          w_cc_mux_nxt = CC_ACKIN;
          w_state_nxt  = S_ENIN;
        end else begin
          w_uscite_nxt = OUT_NORM;
          w_cc_mux_nxt = CC_INTR;
          w_state_nxt  = S_INTR_1;
        end
      end
      S_INTR_1: begin
        if (i_eql) begin
          w_uscite_nxt = OUT_IDLE;
          w_cc_mux_nxt = CC_ACKIN;
          w_state_nxt  = S_INTR;
        end else begin
          w_uscite_nxt = OUT_NORM;
          w_cc_mux_nxt = CC_ENIN;
          w_state_nxt  = S_WAIT;
        end
      end
      S_INTR: begin
        if (i_eql) begin
          w_uscite_nxt = OUT_IDLE;
          w_cc_mux_nxt = CC_ACKIN;
          w_state_nxt  = S_INTR_W;
        end else begin
          w_uscite_nxt = OUT_INTR;
          w_cc_mux_nxt = CC_INTR;
          w_state_nxt  = S_INTR_1;
        end
      end
      S_INTR_W: begin
        if (i_eql) begin
          w_uscite_nxt = OUT_IDLE;
          w_cc_mux_nxt = CC_ACKIN;
          w_state_nxt  = S_INTR_W;
        end else begin
          w_uscite_nxt = OUT_NORM;
          w_cc_mux_nxt = CC_ENIN;
          w_state_nxt  = S_WAIT;
        end
      end
      S_ENIN: begin
        if (i_eql) begin
          w_uscite_nxt = OUT_IDLE;
          w_cc_mux_nxt = CC_ACKIN;
          w_state_nxt  = S_ENIN;
        end else begin
          w_uscite_nxt       = OUT_NORM;
          w_cc_mux_nxt       = CC_INTR;
          w_state_nxt        = S_ENIN_W;
          w_ackout_nxt       = 1'b1;
          w_enable_count_nxt = 1'b0;
        end
      end
      S_ENIN_W: begin
        w_uscite_nxt = OUT_NORM;
        w_cc_mux_nxt = CC_ENIN;
        w_state_nxt  = i_eql ? S_ENIN_W : S_WAIT;
      end
      // S_INIT and the unused encoding both run the init row.
      default: begin
        w_uscite_nxt       = OUT_NORM;
        w_cc_mux_nxt       = CC_ENIN;
        w_state_nxt        = S_WAIT;
        w_enable_count_nxt = 1'b1;
        w_ackout_nxt       = 1'b0;
      end
    endcase
  end

  assign o_cc_mux       = r_cc_mux;
  assign o_uscite       = r_uscite;
  assign o_enable_count = r_enable_count;
  assign o_ackout       = r_ackout;

endmodule : b06_fsm

`default_nettype wire

// File: tb/tb_b06_fsm.sv
// ---------------------------------------------------------------------------
// tb_b06_fsm : directed + random check of b06_fsm against a table-driven model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_b06_fsm;

  logic       clk;
  logic       rst_n;
  logic       i_eql;
  logic       i_cont_eql;
  logic       i_obs;
  logic [1:0] o_cc_mux;
  logic [1:0] o_uscite;
  logic       o_enable_count;
  logic       o_ackout;

  int n_checks = 0;
  int n_errors = 0;

  b06_fsm u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_eql          (i_eql),
    .i_cont_eql     (i_cont_eql),
    .i_obs          (i_obs),
    .o_cc_mux       (o_cc_mux),
    .o_uscite       (o_uscite),
    .o_enable_count (o_enable_count),
    .o_ackout       (o_ackout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model states: 0 INIT, 1 WAIT, 2 INTR_1, 3 INTR, 4 INTR_W, 5 ENIN, 6 ENIN_W.
  // Tables are indexed [state][eql].
  int         NXT [7][2] = '{'{1, 1}, '{2, 5}, '{1, 3}, '{2, 4}, '{1, 4}, '{6, 5}, '{1, 6}};
  logic [1:0] US  [7][2] = '{'{2'b01, 2'b01}, '{2'b01, 2'b00}, '{2'b01, 2'b00},
                             '{2'b11, 2'b00}, '{2'b01, 2'b00}, '{2'b01, 2'b00},
                             '{2'b01, 2'b01}};
  logic [1:0] CC  [7][2] = '{'{2'b01, 2'b01}, '{2'b10, 2'b11}, '{2'b01, 2'b11},
                             '{2'b10, 2'b11}, '{2'b01, 2'b11}, '{2'b10, 2'b11},
                             '{2'b01, 2'b01}};

  int         m_state;
  logic [1:0] m_us;
  logic [1:0] m_cc;
  logic       m_en;
  logic       m_ack;

  task automatic model_reset();
    m_state = 0; m_us = 2'b00; m_cc = 2'b00; m_en = 1'b0; m_ack = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic c);
    int ei;
    ei = e ? 1 : 0;
    if (m_state == 0) begin
      m_en = 1'b1; m_ack = 1'b0;
    end else if (m_state == 5 && !e) begin
      m_en = 1'b0; m_ack = 1'b1;
    end else if (c) begin
      m_en = 1'b0; m_ack = 1'b0;
    end
    m_us    = US[m_state][ei];
    m_cc    = CC[m_state][ei];
    m_state = NXT[m_state][ei];
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".cc_mux"}, o_cc_mux, m_cc);
    chk({tag, ".uscite"}, o_uscite, m_us);
    chk({tag, ".enable_count"}, {1'b0, o_enable_count}, {1'b0, m_en});
    chk({tag, ".ackout"}, {1'b0, o_ackout}, {1'b0, m_ack});
  endtask

  // Apply inputs, clock one edge, compare 1 time unit after the edge.
  task automatic step(input logic e, input logic c, input string tag);
    i_eql      = e;
    i_cont_eql = c;
    i_obs      = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_step(e, c);
    #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    i_eql      = 1'b1;
    i_cont_eql = 1'b0;
    i_obs      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cc_mux", o_cc_mux, 2'b00);
    chk("reset.uscite", o_uscite, 2'b00);
    chk("reset.en_ack", {o_enable_count, o_ackout}, 2'b00);
    rst_n = 1'b1;

    step(1'b1, 1'b0, "init");
    chk("init.literal", {o_cc_mux, o_uscite}, 4'b0101);
    chk("init.en_ack_literal", {o_enable_count, o_ackout}, 2'b10);

    step(1'b0, 1'b0, "wait_to_intr1");
    step(1'b0, 1'b0, "intr1_to_wait");
    chk("intr1_to_wait.literal", o_cc_mux, 2'b01);

    step(1'b1, 1'b0, "wait_to_enin");
    step(1'b0, 1'b0, "enin_exit");
    chk("enin_exit.en_ack_literal", {o_enable_count, o_ackout}, 2'b01);
    step(1'b0, 1'b0, "eninw_to_wait");

    step(1'b0, 1'b1, "cont_clear");
    chk("cont_clear.en_ack_literal", {o_enable_count, o_ackout}, 2'b00);
    step(1'b0, 1'b0, "cont_hold");

    step(1'b0, 1'b0, "to_intr1");
    step(1'b1, 1'b0, "to_intr");
    step(1'b0, 1'b0, "intr_exit");
    chk("intr_exit.literal", {o_uscite, o_cc_mux}, 4'b1110);

    step(1'b0, 1'b0, "intr1_wait");
    step(1'b0, 1'b0, "wait_intr1");
    step(1'b1, 1'b0, "intr1_intr");
    step(1'b1, 1'b0, "intr_intrw");
    step(1'b1, 1'b0, "intrw_hold");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("midreset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), "random");
      if ($urandom_range(0, 1) == 1) i_obs = ~i_obs;
      if ($urandom_range(0, 99) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_all("random_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_b06_fsm

`default_nettype wire
